main_ori_rom_arb: RTL

- Round-robin arbiter and sequencer that shares the single-port main_ori_rom (7-bit address, 6-bit data, registered read) between NREQ requesters in the orientation-assignment stage.
- Each requester presents an address with a valid/ready handshake. The block registers the granted address onto the ROM port and tracks the fixed ROM read latency.
- It returns each data word tagged with the id of the requester that issued the read.
- It sits between the gradient/histogram lanes and the ROM instance.

---
 rtl/main_ori_rom_arb.sv | 108 ++++++++++
 1 files changed

// File: rtl/main_ori_rom_arb.sv
// Round-robin arbiter sharing the single-port orientation ROM between NREQ requesters.
// Each read returns its data tagged with the issuing requester id after a fixed latency.
module main_ori_rom_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 6,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [AW-1:0]      rom_addra,
    input  logic [DW-1:0]      rom_douta,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_data,
    output logic               idle,
    output logic [15:0]        rd_cnt
);

    // Stage 0 lines up with rom_addra; ROM_LAT further stages line up with the ROM read.
    localparam int unsigned PD = ROM_LAT + 1;

    logic [IDW-1:0] r_ptr;
    logic [AW-1:0]  r_rom_addra;
    logic [15:0]    r_rd_cnt;
    logic [PD-1:0]  r_pipe_vld;
    logic [IDW-1:0] r_pipe_id [PD];
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [DW-1:0]  r_rsp_data;

    logic           w_accept;
    logic [IDW-1:0] w_gnt_id;
    logic [AW-1:0]  w_gnt_addr;
    int unsigned    w_idx;

    always_comb begin
        w_accept = 1'b0;
        w_gnt_id = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (32'(r_ptr) + k) % NREQ;
            if (en && !w_accept && (|(req_valid & (NREQ'(1) << w_idx)))) begin
                w_accept = 1'b1;
                w_gnt_id = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        req_ready  = w_accept ? (NREQ'(1) << w_gnt_id) : '0;
        w_gnt_addr = req_addr[w_gnt_id*AW +: AW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_rom_addra <= '0;
            r_rd_cnt    <= '0;
        end else if (w_accept) begin
            r_ptr       <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_rom_addra <= w_gnt_addr;
            r_rd_cnt    <= r_rd_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int unsigned i = 0; i < PD; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_vld   <= {r_pipe_vld[PD-2:0], w_accept};
            r_pipe_id[0] <= w_gnt_id;
            for (int unsigned i = 1; i < PD; i++) begin
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_pipe_vld[PD-1];
            if (r_pipe_vld[PD-1]) begin
                r_rsp_id   <= r_pipe_id[PD-1];
                r_rsp_data <= rom_douta;
            end
        end
    end

    assign rom_addra = r_rom_addra;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rd_cnt    = r_rd_cnt;
    assign idle      = ~(|r_pipe_vld) & ~w_accept & ~r_rsp_valid;

endmodule
